// File: rtl/pattern_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package pattern_pkg;

  localparam int PAT_MAX_LEN = 16;
  localparam int PAT_REP_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } pat_state_t;

endpackage

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated
// back-to-back a requested number of times, with stall and abort control.
module pattern_tx
  import pattern_pkg::*;
#(
  parameter  int MAX_LEN = PAT_MAX_LEN,
  parameter  int REP_W   = PAT_REP_W,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  input  logic               stall,
  input  logic               abort,
  output logic               a,
  output logic               a_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  pat_state_t         state;
  pat_state_t         state_nxt;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] shreg;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   bit_idx;
  logic [REP_W-1:0]   reps_q;
  logic [REP_W-1:0]   rep_cnt;
  logic               handshake;
  logic               req_empty;
  logic               last_bit;
  logic               advance;

  // Left-justify the pattern so its bit len-1 sits at the shifter MSB.
  function automatic logic [MAX_LEN-1:0] align_msb(input logic [MAX_LEN-1:0] p,
                                                   input logic [LEN_W-1:0]   l);
    return p << (MAX_LEN_L - l);
  endfunction

  assign handshake = start_valid && (state == IDLE);
  assign req_empty = (len == '0) || (reps == '0) || (len > MAX_LEN_L);
  assign last_bit  = (bit_idx == '0) && ((rep_cnt + 1'b1) == reps_q);
  assign advance   = (state == SEND) && !abort && !stall;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nxt = req_empty ? DONE : SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!stall && last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The shifter is cleared on every exit from SEND so a reads 0 outside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= '0;
      len_q   <= '0;
      reps_q  <= '0;
      bit_idx <= '0;
      rep_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            pat_q   <= pat;
            len_q   <= len;
            reps_q  <= reps;
            rep_cnt <= '0;
            bit_idx <= req_empty ? '0 : len - 1'b1;
            shreg   <= req_empty ? '0 : align_msb(pat, len);
          end
        end
        SEND: begin
          if (abort || (advance && last_bit)) begin
            shreg <= '0;
          end else if (advance) begin
            if (bit_idx == '0) begin
              bit_idx <= len_q - 1'b1;
              rep_cnt <= rep_cnt + 1'b1;
              shreg   <= align_msb(pat_q, len_q);
            end else begin
              bit_idx <= bit_idx - 1'b1;
              shreg   <= shreg << 1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign a           = shreg[MAX_LEN-1];
  assign a_valid     = (state == SEND) && !stall;
  assign busy        = (state == SEND);
  assign done        = (state == DONE);
  assign start_ready = (state == IDLE);

endmodule
